// File: rtl/clk_div_pkg.sv
// Shared types and defaults for the clk_div configuration controller.
// Holds the controller state encoding and the divider's default width/ratio.
package clk_div_pkg;

    localparam int DEF_W       = 8;
    localparam int DEF_DIV_RST = 5;

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT_EDGE,
        S_SETTLE,
        S_DONE
    } clk_div_ctl_state_t;

endpackage

// File: rtl/clk_div_ctl_rr_arb.sv
// N-bit round-robin arbiter, purely combinational.
// Grants the first set request at or after ptr, wrapping around.
module rr_arb #(
    parameter int N  = 4,
    parameter int IW = $clog2(N)
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] ptr,
    output logic [IW-1:0] gnt_id,
    output logic          valid
);

    // scan from farthest to nearest so the nearest hit wins last
    always_comb begin
        valid  = 1'b0;
        gnt_id = '0;
        for (int i = N - 1; i >= 0; i--) begin
            if (req[(int'(ptr) + i) % N]) begin
                valid  = 1'b1;
                gnt_id = IW'((int'(ptr) + i) % N);
            end
        end
    end

endmodule

// File: rtl/clk_div_ctl.sv
// Shares one clk_div instance between N requesters: arbitrates ratio changes,
// applies them on a divided-clock falling edge and acks after a settle time.
module clk_div_ctl
    import clk_div_pkg::*;
#(
    parameter int W       = DEF_W,
    parameter int N       = 4,
    parameter int SETTLE  = 4,
    parameter int DIV_RST = DEF_DIV_RST
) (
    input  logic                 clk_i,
    input  logic                 rst_n_i,
    input  logic [N-1:0]         req_i,
    input  logic [N*W-1:0]       div_req_i,
    input  logic                 clk_div_i,
    output logic [W-1:0]         div_o,
    output logic [N-1:0]         ack_o,
    output logic                 err_o,
    output logic                 busy_o,
    output logic [$clog2(N)-1:0] cur_id_o
);

    localparam int IW = $clog2(N);
    localparam int CW = W + 2;
    localparam int SW = $clog2(SETTLE + 1);
    localparam logic [CW-1:0] TMO_MAX = CW'((1 << (W + 1)) - 1);
    localparam logic [SW-1:0] SET_MAX = SW'(SETTLE - 1);

    clk_div_ctl_state_t state;

    logic [IW-1:0] ptr;
    logic [IW-1:0] gnt_id;
    logic          gnt_vld;
    logic [W-1:0]  gnt_val;
    logic [W-1:0]  val_q;
    logic [CW-1:0] tmo_cnt;
    logic [SW-1:0] set_cnt;
    logic          clk_div_q;
    logic          fall;
    logic [IW-1:0] ptr_nxt;

    function automatic logic [N-1:0] onehot(input logic [IW-1:0] id);
        return N'(1) << id;
    endfunction

    rr_arb #(
        .N  (N),
        .IW (IW)
    ) u_arb (
        .req    (req_i),
        .ptr    (ptr),
        .gnt_id (gnt_id),
        .valid  (gnt_vld)
    );

    assign gnt_val = div_req_i[int'(gnt_id)*W +: W];
    assign fall    = clk_div_q & ~clk_div_i;
    assign ptr_nxt = (int'(cur_id_o) == N - 1) ? '0 : cur_id_o + 1'b1;

    // controller FSM with registered outputs, counters and edge detector
    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            state     <= S_IDLE;
            div_o     <= W'(DIV_RST);
            ack_o     <= '0;
            err_o     <= 1'b0;
            busy_o    <= 1'b0;
            cur_id_o  <= '0;
            ptr       <= '0;
            val_q     <= '0;
            tmo_cnt   <= '0;
            set_cnt   <= '0;
            clk_div_q <= 1'b0;
        end else begin
            clk_div_q <= clk_div_i;
            ack_o     <= '0;
            err_o     <= 1'b0;
            unique case (state)
                S_IDLE: begin
                    if (gnt_vld) begin
                        cur_id_o <= gnt_id;
                        val_q    <= gnt_val;
                        tmo_cnt  <= '0;
                        busy_o   <= 1'b1;
                        if (gnt_val == '0) begin
                            ack_o <= onehot(gnt_id);
                            err_o <= 1'b1;
                            state <= S_DONE;
                        end else if (gnt_val == div_o) begin
                            ack_o <= onehot(gnt_id);
                            state <= S_DONE;
                        end else begin
                            state <= S_WAIT_EDGE;
                        end
                    end
                end
                S_WAIT_EDGE: begin
                    // a stalled divider never falls, so the timeout forces it
                    if (fall || tmo_cnt == TMO_MAX) begin
                        div_o   <= val_q;
                        set_cnt <= '0;
                        state   <= S_SETTLE;
                    end else begin
                        tmo_cnt <= tmo_cnt + 1'b1;
                    end
                end
                S_SETTLE: begin
                    if (set_cnt == SET_MAX) begin
                        ack_o <= onehot(cur_id_o);
                        state <= S_DONE;
                    end else begin
                        set_cnt <= set_cnt + 1'b1;
                    end
                end
                S_DONE: begin
                    ptr    <= ptr_nxt;
                    busy_o <= 1'b0;
                    state  <= S_IDLE;
                end
                default: begin
                    busy_o <= 1'b0;
                    state  <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_clk_div_ctl.sv
// Directed bench for clk_div_ctl with a behavioural divider in the loop.
// Table of arbitration vectors plus hand sequences for timing corners.
module tb_clk_div_ctl;

    logic        clk;
    logic        rst_n;
    logic [3:0]  req;
    logic [31:0] div_req;
    logic        clk_div;
    logic [7:0]  div;
    logic [3:0]  ack;
    logic        err;
    logic        busy;
    logic [1:0]  cur_id;

    logic        force_low;
    logic [7:0]  dcnt;
    logic        dq;

    int vectors;
    int miscompares;

    clk_div_ctl #(
        .W       (8),
        .N       (4),
        .SETTLE  (4),
        .DIV_RST (5)
    ) dut (
        .clk_i     (clk),
        .rst_n_i   (rst_n),
        .req_i     (req),
        .div_req_i (div_req),
        .clk_div_i (clk_div),
        .div_o     (div),
        .ack_o     (ack),
        .err_o     (err),
        .busy_o    (busy),
        .cur_id_o  (cur_id)
    );

    always #5 clk = ~clk;

    // behavioural divider: output toggles every div_o cycles
    always @(posedge clk) begin
        if (!rst_n) begin
            dcnt <= '0;
            dq   <= 1'b0;
        end else if (int'(dcnt) + 1 >= int'(div)) begin
            dcnt <= '0;
            dq   <= ~dq;
        end else begin
            dcnt <= dcnt + 1'b1;
        end
    end

    assign clk_div = force_low ? 1'b0 : dq;

    typedef struct {
        logic [3:0]      req;
        logic [31:0]     vals;
        int              n;
        logic [3:0][1:0] ids;
        logic [3:0]      errs;
        logic [7:0]      div;
    } vec_t;

    vec_t tbl[5];

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        int bad;
        int got;
        int cyc;
        int fell;
        logic prev;

        clk = 0; rst_n = 0; req = 0; div_req = 0; force_low = 0;
        vectors = 0; miscompares = 0;

        tbl[0] = '{4'b1111, 32'h04030201, 4,
                   {2'd3, 2'd2, 2'd1, 2'd0}, 4'b0000, 8'h04};
        tbl[1] = '{4'b1010, 32'h04000200, 2,
                   {2'd0, 2'd0, 2'd3, 2'd1}, 4'b0000, 8'h04};
        tbl[2] = '{4'b0100, 32'h11000011, 1,
                   {2'd0, 2'd0, 2'd0, 2'd2}, 4'b0001, 8'h04};
        tbl[3] = '{4'b0001, 32'h00000004, 1,
                   {2'd0, 2'd0, 2'd0, 2'd0}, 4'b0000, 8'h04};
        tbl[4] = '{4'b1001, 32'h07000009, 2,
                   {2'd0, 2'd0, 2'd0, 2'd3}, 4'b0000, 8'h09};

        // reset and quiet idle
        do_reset();
        chk("rst_div", 32'(div), 32'h05);
        chk("rst_cur_id", 32'(cur_id), 0);
        bad = 0;
        repeat (100) begin
            @(negedge clk);
            if (div !== 8'h05 || ack !== 4'b0 || err !== 1'b0 ||
                busy !== 1'b0)
                bad++;
        end
        chk("idle_quiet", bad, 0);

        // normal path: requester 0 asks for 3
        div_req = 32'h00000003;
        req = 4'b0001;
        prev = clk_div;
        @(negedge clk);
        chk("norm_busy", 32'(busy), 1);
        chk("norm_cur_id", 32'(cur_id), 0);
        req = 4'b0000;
        fell = 0;
        for (int i = 0; i < 200 && fell == 0; i++) begin
            if (prev == 1'b1 && clk_div == 1'b0) fell = 1;
            else begin
                prev = clk_div;
                @(negedge clk);
            end
        end
        chk("norm_fall_seen", fell, 1);
        @(negedge clk);
        chk("norm_div", 32'(div), 32'h03);
        bad = 0;
        repeat (3) begin
            @(negedge clk);
            if (ack !== 4'b0) bad++;
        end
        chk("norm_no_early_ack", bad, 0);
        @(negedge clk);
        chk("norm_ack", 32'(ack), 32'h1);
        chk("norm_err", 32'(err), 0);
        @(negedge clk);
        chk("norm_ack_clr", 32'(ack), 0);
        chk("norm_idle", 32'(busy), 0);

        // reject: value 0 on requester 2
        div_req = 32'h00000000;
        req = 4'b0100;
        @(negedge clk);
        req = 4'b0000;
        chk("rej_ack", 32'(ack), 32'h4);
        chk("rej_err", 32'(err), 1);
        chk("rej_cur_id", 32'(cur_id), 2);
        @(negedge clk);
        chk("rej_ack_clr", 32'(ack), 0);
        chk("rej_idle", 32'(busy), 0);
        chk("rej_div", 32'(div), 32'h03);

        // equal value on requester 1: no edge wait, no error
        div_req = 32'h00000300;
        req = 4'b0010;
        @(negedge clk);
        req = 4'b0000;
        chk("eq_ack", 32'(ack), 32'h2);
        chk("eq_err", 32'(err), 0);
        @(negedge clk);
        chk("eq_idle", 32'(busy), 0);

        // table of arbitration vectors from a fresh pointer
        do_reset();
        for (int v = 0; v < 5; v++) begin
            div_req = tbl[v].vals;
            req = tbl[v].req;
            got = 0;
            cyc = 0;
            while (got < tbl[v].n && cyc < 3000) begin
                @(negedge clk);
                cyc++;
                if (ack !== 4'b0) begin
                    chk($sformatf("tbl%0d_ack%0d", v, got), 32'(ack),
                        32'(4'b1 << tbl[v].ids[got]));
                    chk($sformatf("tbl%0d_err%0d", v, got), 32'(err),
                        32'(tbl[v].errs[got]));
                    req = req & ~ack;
                    got++;
                end
            end
            chk($sformatf("tbl%0d_ack_count", v), got, tbl[v].n);
            req = 4'b0000;
            @(negedge clk);
            chk($sformatf("tbl%0d_div", v), 32'(div), 32'(tbl[v].div));
            chk($sformatf("tbl%0d_idle", v), 32'(busy), 0);
        end

        // stalled divider: timeout forces the update
        force_low = 1'b1;
        repeat (2) @(negedge clk);
        div_req = 32'h00000010;
        req = 4'b0001;
        bad = 0;
        for (int n = 1; n <= 517; n++) begin
            @(negedge clk);
            if (n == 1) req = 4'b0000;
            if (n == 512) chk("tmo_div_before", 32'(div), 32'h09);
            if (n == 513) chk("tmo_div_after", 32'(div), 32'h10);
            if (n < 517 && ack !== 4'b0) bad++;
            if (n == 517) chk("tmo_ack", 32'(ack), 32'h1);
        end
        chk("tmo_no_early_ack", bad, 0);
        force_low = 1'b0;
        @(negedge clk);

        // reset during settle aborts service
        div_req = 32'h00002000;
        req = 4'b0010;
        @(negedge clk);
        req = 4'b0000;
        cyc = 0;
        while (div !== 8'h20 && cyc < 300) begin
            @(negedge clk);
            cyc++;
        end
        chk("rst_settle_reached", 32'(div), 32'h20);
        rst_n = 1'b0;
        @(negedge clk);
        chk("rst_settle_div", 32'(div), 32'h05);
        chk("rst_settle_busy", 32'(busy), 0);
        bad = 0;
        repeat (2) begin
            if (ack !== 4'b0) bad++;
            @(negedge clk);
        end
        rst_n = 1'b1;
        repeat (8) begin
            @(negedge clk);
            if (ack !== 4'b0 || busy !== 1'b0) bad++;
        end
        chk("rst_settle_no_ack", bad, 0);

        $display("== %0d vectors applied, %0d miscompares ==",
                 vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/clk_div_ctl.md
# clk_div_ctl

Configuration controller for the `clk_div` programmable divider. It lets N requesters share one divider. Pending divide-ratio change requests are arbitrated round-robin. The winning value is applied to the divider's `div_i` only at a falling edge of the divided clock, so no runt pulse is produced. The winner receives an acknowledge pulse after a fixed settle time. The block sits between the clock-consumer blocks and the single `clk_div` instance, and drives that instance's `div_i`.

## Interface
- W, 8, divide-ratio width (matches `clk_div`)
- N, 4, number of requesters (≥2)
- SETTLE, 4, cycles to hold after a ratio change before acknowledging (≥1)
- DIV_RST, 5, divide ratio driven while in reset

- clk_i  in  1  system clock; single clock domain
- rst_n_i  in  1  reset; synchronous, active-low
- req_i  in  N  level request per requester
- div_req_i  in  N*W  requested ratio; requester k at [k*W +: W]
- clk_div_i  in  1  `clk_o` of the divider, fed back; synchronous to clk_i
- div_o  out  W  to divider `div_i`
- ack_o  out  N  one-cycle completion pulse, one-hot
- err_o  out  1  one-cycle pulse with ack_o when the request was rejected
- busy_o  out  1  high while a request is in service
- cur_id_o  out  $clog2(N)  requester currently or last served

## Operation
- States: IDLE, WAIT_EDGE, SETTLE, DONE.
- IDLE:
  - If any req_i is high, grant the first set bit at or after ptr (round-robin, wrapping).
  - Latch the grant id into cur_id_o and latch the value.
  - Value == 0: reject. Go to DONE with err flag; div_o is unchanged.
  - Value == div_o: go to DONE directly; no edge wait.
  - Otherwise: go to WAIT_EDGE and clear the timeout counter.
- WAIT_EDGE:
  - Falling edge = registered clk_div_q==1 && clk_div_i==0.
  - On a falling edge, load div_o with the latched value, go to SETTLE, and clear the settle counter.
  - Timeout: the counter (W+2 bits) reaching 2^(W+1)-1 without an edge forces the same update (covers a stalled divider).
- SETTLE: count SETTLE cycles, then go to DONE.
- DONE:
  - ack_o[id] = 1 and err_o = err flag for this one cycle.
  - ptr ← (id+1) mod N.
  - Return to IDLE.
- busy_o = (state != IDLE).
- req_i is ignored outside IDLE.
- A request dropped mid-service still completes and is acked.
- A req_i still high in the IDLE cycle after its ack is a new request and is arbitrated normally.
- div_req_i is sampled only in IDLE at grant. Later changes are ignored.
- Reset values: state IDLE, div_o = DIV_RST, ack_o = 0, err_o = 0, busy_o = 0, cur_id_o = 0, ptr = 0, clk_div_q = 0, counters = 0.
- Reset asserted in any state aborts service on the next edge: no ack, div_o returns to DIV_RST.

## Timing
- Grant at edge t (IDLE with req): busy_o = 1 from t+1.
- Normal path:
  - Falling edge detected in cycle e: div_o is new from edge e+1.
  - ack_o from e+1+SETTLE for one cycle.
  - IDLE again at e+2+SETTLE.
- Reject/equal path: ack_o (and err_o for a reject) is high in cycle t+1; IDLE at t+2.
- Minimum spacing between two acks is 2 cycles.
- Timeout path: div_o updates 2^(W+1) cycles after entering WAIT_EDGE.
- All outputs are registered; there is no combinational path from inputs to outputs.

## Structure
- Package `clk_div_pkg`: state enum `clk_div_ctl_state_t` and the default constants for W and DIV_RST.
- Sub-module `rr_arb` (N-bit round-robin arbiter):
  - Inputs: req and ptr.
  - Outputs: grant id and valid.
  - Combinational.
- FSM, counters and edge detector stay in `clk_div_ctl`.

## Test plan
The bench uses N=4, W=8, SETTLE=4, DIV_RST=5, with a real `clk_div` whose div_i = div_o and whose clk_o drives clk_div_i.
- Reset, then release with no requests → div_o = 0x05, ack_o = 0, err_o = 0, busy_o = 0 for 100 cycles.
- req_i = 0001 with value 0x03 → busy_o is high next cycle. div_o = 0x03 one cycle after the first clk_div_i fall. ack_o = 0001 exactly 4 cycles later.
- req_i = 1111 with values 1, 2, 3, 4 held → acks in order 0, 1, 2, 3 and div_o ends at 0x04. Then req_i = 1010 → requester 1 is served before 3.
- Value 0x00 on requester 2 → ack_o = 0100 with err_o = 1 at t+1; div_o unchanged. Value equal to current div_o → ack at t+1, err_o = 0.
- Force clk_div_i = 0 → div_o updates 512 cycles after entering WAIT_EDGE, then ack 4 cycles later.
- Assert rst_n_i during SETTLE → no ack. On the next edge div_o = 0x05 and busy_o = 0.
